// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus with registered one-hot grant.
// Split parking/resume is built only when ARB_SPLIT_EN is defined.
module serial_bus_arbiter #(
  parameter int NUM_INIT = 2,
  parameter int OWNER_W  = $clog2(NUM_INIT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INIT-1:0] req,
  input  logic                txn_done,
  input  logic                target_split,
  input  logic                split_resume,
  output logic [NUM_INIT-1:0] grant,
  output logic [OWNER_W-1:0]  owner_id,
  output logic                bus_idle,
  output logic                split_pending,
  output logic [OWNER_W-1:0]  split_owner,
  output logic                split_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  logic [1:0]          state;
  logic [OWNER_W-1:0]  last_owner;
  logic [NUM_INIT-1:0] cand;
  logic                rr_found;
  logic [OWNER_W-1:0]  rr_win;
  logic [OWNER_W:0]    rr_idx;
  logic                resume_win;
  logic                release_bus;
  logic [NUM_INIT-1:0] rr_onehot;
  logic [NUM_INIT-1:0] resume_onehot;

`ifdef ARB_SPLIT_EN
  // A parked initiator may not win round-robin until its target resumes it.
  always_comb begin
    cand = req;
    if (split_pending) cand[split_owner] = 1'b0;
  end

  assign resume_win = split_pending & split_resume;
`else
  logic split_unused;

  assign cand         = req;
  assign resume_win   = 1'b0;
  assign split_unused = split_resume;
`endif

  // Search starts one past the last owner; wrap uses a compare so any NUM_INIT works.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_INIT; k++) begin
      rr_idx = {1'b0, last_owner} + (OWNER_W+1)'(k);
      if (rr_idx >= (OWNER_W+1)'(NUM_INIT)) rr_idx = rr_idx - (OWNER_W+1)'(NUM_INIT);
      if (!rr_found && cand[rr_idx[OWNER_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[OWNER_W-1:0];
      end
    end
  end

  assign rr_onehot     = NUM_INIT'(1) << rr_win;
  assign resume_onehot = NUM_INIT'(1) << split_owner;
  assign release_bus   = txn_done | target_split | ~req[owner_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      owner_id   <= '0;
      bus_idle   <= 1'b1;
      last_owner <= OWNER_W'(NUM_INIT - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (resume_win) begin
            // Resume grant leaves last_owner alone so rotation fairness is kept.
            grant    <= resume_onehot;
            owner_id <= split_owner;
            bus_idle <= 1'b0;
            state    <= ST_BUSY;
          end else if (rr_found) begin
            grant      <= rr_onehot;
            owner_id   <= rr_win;
            last_owner <= rr_win;
            bus_idle   <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_bus) begin
            grant    <= '0;
            bus_idle <= 1'b1;
            state    <= ST_TURN;
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: begin
          grant    <= '0;
          bus_idle <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_SPLIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_pending <= 1'b0;
      split_owner   <= '0;
      split_err     <= 1'b0;
    end else begin
      split_err <= 1'b0;
      if (state == ST_IDLE && resume_win) begin
        split_pending <= 1'b0;
      end else if (state == ST_BUSY && target_split) begin
        // Only one parked transaction; a second split is flagged and released.
        if (!split_pending) begin
          split_pending <= 1'b1;
          split_owner   <= owner_id;
        end else begin
          split_err <= 1'b1;
        end
      end
    end
  end
`else
  assign split_pending = 1'b0;
  assign split_owner   = '0;
  assign split_err     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: expected grants queued at stimulus, popped on each new grant.
module tb_serial_bus_arbiter;

  localparam int NUM_INIT = 2;
  localparam int OWNER_W  = 1;

  logic                clk;
  logic                rst_n;
  logic [NUM_INIT-1:0] req;
  logic                txn_done;
  logic                target_split;
  logic                split_resume;
  logic [NUM_INIT-1:0] grant;
  logic [OWNER_W-1:0]  owner_id;
  logic                bus_idle;
  logic                split_pending;
  logic [OWNER_W-1:0]  split_owner;
  logic                split_err;

  logic [NUM_INIT-1:0] exp_q[$];
  logic [NUM_INIT-1:0] prev_grant;
  int checks = 0;
  int errors = 0;

  serial_bus_arbiter #(.NUM_INIT(NUM_INIT), .OWNER_W(OWNER_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .txn_done     (txn_done),
    .target_split (target_split),
    .split_resume (split_resume),
    .grant        (grant),
    .owner_id     (owner_id),
    .bus_idle     (bus_idle),
    .split_pending(split_pending),
    .split_owner  (split_owner),
    .split_err    (split_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, (n < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Release via txn_done, then confirm the grant is low after edges N and N+1.
  task automatic release_gap(input string tag);
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check({tag, "_drop"}, grant, 0);
    check({tag, "_idle"}, bus_idle, 1);
    tick();
    check({tag, "_turn"}, grant, 0);
  endtask

  // scoreboard monitor: each new grant must match the head of exp_q
  always begin
    @(posedge clk);
    #2;
    if (grant != '0 && prev_grant == '0) begin
      if (exp_q.size() == 0) check("sb_unexpected", grant, 0);
      else check("sb_grant", grant, exp_q.pop_front());
    end else if (grant != '0 && prev_grant != '0) begin
      check("sb_hold", grant, prev_grant);
    end
    prev_grant = grant;
  end

  initial begin
    prev_grant   = '0;
    rst_n        = 1'b0;
    req          = '0;
    txn_done     = 1'b0;
    target_split = 1'b0;
    split_resume = 1'b0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_owner", owner_id, 0);
    check("rst_idle", bus_idle, 1);
    check("rst_pend", split_pending, 0);
    check("rst_sowner", split_owner, 0);
    check("rst_serr", split_err, 0);
    rst_n = 1'b1;
    tick();

    // single request
    req = 2'b01;
    exp_q.push_back(2'b01);
    tick();
    check("single_grant", grant, 2'b01);
    check("single_owner", owner_id, 0);
    check("single_idle", bus_idle, 0);
    tick();
    tick();
    check("single_held", grant, 2'b01);
    req = 2'b00;
    release_gap("single");
    check("single_owner_kept", owner_id, 0);
    tick();
    check("single_no_regrant", grant, 0);

    // round-robin with both requesting; last owner was 0
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [NUM_INIT-1:0] e;
      e = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_q.push_back(e);
      if (i == 0) wait_grant("rr_wait");
      else begin
        tick();
        check("rr_edge_n2", (grant != '0) ? 32'd1 : 32'd0, 1);
      end
      check("rr_owner", owner_id, (i % 2 == 0) ? 1 : 0);
      repeat (4) tick();
      check("rr_held", grant, e);
      if (i == 3) req = 2'b00;
      release_gap("rr");
    end

    // reset during BUSY drops the grant asynchronously
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_grant("rstb_wait");
    tick();
    rst_n = 1'b0;
    #1;
    check("rstb_grant", grant, 0);
    check("rstb_idle", bus_idle, 1);
    check("rstb_pend", split_pending, 0);
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ARB_SPLIT_EN
    // split park: after reset initiator 0 has priority
    req = 2'b11;
    exp_q.push_back(2'b01);
    wait_grant("sp_wait0");
    check("sp_owner0", owner_id, 0);
    target_split = 1'b1;
    tick();
    target_split = 1'b0;
    check("sp_drop", grant, 0);
    check("sp_pend", split_pending, 1);
    check("sp_sowner", split_owner, 0);
    check("sp_err_none", split_err, 0);
    exp_q.push_back(2'b10);
    wait_grant("sp_wait1");
    check("sp_owner1", owner_id, 1);
    // initiator 0 stays masked while parked
    exp_q.push_back(2'b10);
    release_gap("sp_mask");
    wait_grant("sp_wait1b");
    check("sp_still_pend", split_pending, 1);

    // resume beats round-robin
    split_resume = 1'b1;
    tick();
    exp_q.push_back(2'b01);
    release_gap("sp_res");
    wait_grant("sp_wait_res");
    check("sp_res_owner", owner_id, 0);
    check("sp_res_clear", split_pending, 0);
    split_resume = 1'b0;

    // park 0 again, then a second split from owner 1
    target_split = 1'b1;
    tick();
    target_split = 1'b0;
    check("ds_pend", split_pending, 1);
    exp_q.push_back(2'b10);
    wait_grant("ds_wait1");
    tick();
    target_split = 1'b1;
    tick();
    target_split = 1'b0;
    check("ds_err", split_err, 1);
    check("ds_drop", grant, 0);
    check("ds_sowner", split_owner, 0);
    check("ds_pend_kept", split_pending, 1);
    tick();
    check("ds_err_pulse", split_err, 0);
    exp_q.push_back(2'b10);
    wait_grant("ds_wait1b");
    split_resume = 1'b1;
    exp_q.push_back(2'b01);
    release_gap("ds_res");
    wait_grant("ds_wait_res");
    check("ds_res_clear", split_pending, 0);
    split_resume = 1'b0;
    req = 2'b00;
    release_gap("ds_end");
`else
    // without split support target_split is a plain release
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_grant("ns_wait");
    split_resume = 1'b1;
    target_split = 1'b1;
    tick();
    target_split = 1'b0;
    check("ns_drop", grant, 0);
    check("ns_pend", split_pending, 0);
    check("ns_err", split_err, 0);
    check("ns_sowner", split_owner, 0);
    req = 2'b00;
    tick();
    tick();
    tick();
    check("ns_resume_ignored", grant, 0);
    split_resume = 1'b0;
    // a fresh request after the split-release is granted normally
    req = 2'b10;
    exp_q.push_back(2'b10);
    wait_grant("ns_wait2");
    check("ns_owner", owner_id, 1);
    req = 2'b00;
    release_gap("ns_end");
`endif

    tick();
    tick();
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
